// File: rtl/alu_pkg.sv
// Shared ALU control codes and requester indices for the ALU-sharing arbiter.
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    localparam int REQ_EXE = 0;
    localparam int REQ_BR  = 1;

endpackage

// File: rtl/alu_share_arbiter_rsp_slot.sv
// Per-requester response holder: captures the shared ALU output on grant and
// keeps it until the requester consumes it.
module rsp_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             consume,
    input  logic [WIDTH-1:0] result_in,
    input  logic             zero_in,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Load wins over consume so a drain-and-regrant cycle keeps valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            result <= result_in;
            zero   <= zero_in;
        end else if (consume) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute-stage
// operand path and the branch/address helper.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [3:0]       req_ctrl0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_ctrl1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result0,
    output logic             rsp_zero0,
    output logic [WIDTH-1:0] rsp_result1,
    output logic             rsp_zero1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    logic [1:0] eligible;
    logic [1:0] grant;
    logic       last_grant;

    // A slot can accept a new result when empty or being drained this cycle.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (&eligible) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[REQ_BR];
        end
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = CTRL_AND;
        if (grant[REQ_EXE]) begin
            alu_a    = req_a0;
            alu_b    = req_b0;
            alu_ctrl = req_ctrl0;
        end else if (grant[REQ_BR]) begin
            alu_a    = req_a1;
            alu_b    = req_b1;
            alu_ctrl = req_ctrl1;
        end
    end

    rsp_slot #(.WIDTH(WIDTH)) u_slot_exe (
        .clk       (clk),
        .reset     (reset),
        .load      (grant[REQ_EXE]),
        .consume   (rsp_ready[REQ_EXE]),
        .result_in (alu_result),
        .zero_in   (alu_zero),
        .valid     (rsp_valid[REQ_EXE]),
        .result    (rsp_result0),
        .zero      (rsp_zero0)
    );

    rsp_slot #(.WIDTH(WIDTH)) u_slot_br (
        .clk       (clk),
        .reset     (reset),
        .load      (grant[REQ_BR]),
        .consume   (rsp_ready[REQ_BR]),
        .result_in (alu_result),
        .zero_in   (alu_zero),
        .valid     (rsp_valid[REQ_BR]),
        .result    (rsp_result1),
        .zero      (rsp_zero1)
    );

endmodule
